// File: rtl/systolic_act_feeder_if.sv
// Activation input stream into the feeder: one ROWS-lane vector per beat plus a burst-end flag.
// A beat transfers on a rising edge where in_valid && in_ready; the source holds in_vec/in_last stable while in_valid is high and in_ready is low.
interface systolic_act_feeder_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*WORD_WIDTH-1:0] in_vec;
  logic                       in_last;

  modport master (output in_valid, output in_vec, output in_last, input in_ready);
  modport slave  (input in_valid, input in_vec, input in_last, output in_ready);
endinterface

// File: rtl/systolic_act_feeder.sv
// Activation feeder for the weight-stationary PE array: FIFO-buffered vectors are popped in
// STREAM and skewed diagonally so lane r reaches PE row r r cycles after lane 0.
module systolic_act_feeder #(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  systolic_act_feeder_if.slave       act,
  output logic [1:0]                 control_out,
  output logic [ROWS*WORD_WIDTH-1:0] a_out,
  output logic [ROWS-1:0]            a_valid,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(ROWS);
  localparam int VW  = ROWS * WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t st;
  logic [DCW-1:0] drain_cnt;

  // FIFO entries hold {last, vector}
  logic [VW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [VW:0]   head;

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign act.in_ready = !full;
  assign push         = act.in_valid && !full;
  assign pop          = (st == STREAM) && !empty;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {act.in_last, act.in_vec};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= IDLE;
      control_out <= 2'b00;
      drain_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st          <= STREAM;
            control_out <= 2'b10;
          end
        end
        STREAM: begin
          if (pop && head[VW]) begin
            st        <= DRAIN;
            drain_cnt <= DCW'(ROWS - 1);
          end
        end
        DRAIN: begin
          // done coincides with the last lane ROWS-1 datum on a_out
          if (drain_cnt == '0) begin
            st          <= IDLE;
            control_out <= 2'b00;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
            done      <= (drain_cnt == DCW'(1));
          end
        end
        default: begin
          st          <= IDLE;
          control_out <= 2'b00;
        end
      endcase
    end
  end

  assign busy  = (st != IDLE);
  assign state = st;

  // Lane r is a chain of r+1 {valid, data} registers; bubbles and drain zeros keep alignment
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WORD_WIDTH:0] feed;
    logic [WORD_WIDTH:0] pipe [0:r];

    assign feed = pop ? {1'b1, head[r*WORD_WIDTH +: WORD_WIDTH]} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k <= r; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= feed;
        for (int k = 1; k <= r; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign a_out[r*WORD_WIDTH +: WORD_WIDTH] = pipe[r][WORD_WIDTH-1:0];
    assign a_valid[r]                        = pipe[r][WORD_WIDTH];
  end

endmodule

// File: tb/tb_systolic_act_feeder.sv
// Directed bench for systolic_act_feeder: table-driven skew burst plus hand-written
// back-pressure, bubble, ignored-start and mid-burst reset sequences.
module tb_systolic_act_feeder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  control_out;
  logic [31:0] a_out;
  logic [3:0]  a_valid;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  systolic_act_feeder_if #(.WORD_WIDTH(8), .ROWS(4)) act ();

  systolic_act_feeder #(.WORD_WIDTH(8), .ROWS(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .act         (act),
    .control_out (control_out),
    .a_out       (a_out),
    .a_valid     (a_valid),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        vld;
    logic [31:0] vec;
    logic        last;
    logic [31:0] e_a;
    logic [3:0]  e_v;
    logic [1:0]  e_ctrl;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t tbl [8];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] d, input logic l);
    start        = s;
    act.in_valid = v;
    act.in_vec   = d;
    act.in_last  = l;
  endtask

  function automatic logic [31:0] vk(input int k);
    return {8'(k*16+3), 8'(k*16+2), 8'(k*16+1), 8'(k*16)};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_a, input logic [3:0] e_v,
                            input logic [1:0] e_ctrl, input logic e_busy, input logic e_done,
                            input logic e_ready);
    check({tag, ".a_out"},    64'(a_out),        64'(e_a));
    check({tag, ".a_valid"},  64'(a_valid),      64'(e_v));
    check({tag, ".control"},  64'(control_out),  64'(e_ctrl));
    check({tag, ".busy"},     64'(busy),         64'(e_busy));
    check({tag, ".done"},     64'(done),         64'(e_done));
    check({tag, ".in_ready"}, 64'(act.in_ready), 64'(e_ready));
  endtask

  initial begin
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 reset_n = 1'b0;
    #2;
    check_outs("reset", 32'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("reset.state", 64'(state), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Skew burst: prefill one vector with last, then start
    tbl[0] = '{1'b0, 1'b1, 32'h04030201, 1'b1, 32'h00000000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00000001, 4'b0001, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00000200, 4'b0010, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00030000, 4'b0100, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h04000000, 4'b1000, 2'b10, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00000000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].start, tbl[i].vld, tbl[i].vec, tbl[i].last);
      tick();
      check_outs($sformatf("skew[%0d]", i), tbl[i].e_a, tbl[i].e_v, tbl[i].e_ctrl,
                 tbl[i].e_busy, tbl[i].e_done, tbl[i].e_ready);
    end
    check("skew.state_idle", 64'(state), 64'd0);

    // Back-pressure: four pushes fill the FIFO, the fifth is held
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, vk(k), 1'b0);
      tick();
      check($sformatf("bp.ready_after_push%0d", k), 64'(act.in_ready), (k < 4) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 1'b1, vk(5), 1'b1);
    tick();
    check("bp.held_ready", 64'(act.in_ready), 64'd0);
    check("bp.held_state", 64'(state), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bp.stream_state", 64'(state), 64'd1);
    check("bp.full_in_stream", 64'(act.in_ready), 64'd0);
    done_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 2) drive(1'b0, 1'b0, 32'h0, 1'b0);
      done_cnt += int'(done);
      if (i == 1) check("bp.ready_after_pop", 64'(act.in_ready), 64'd1);
      if (i <= 5) begin
        check($sformatf("bp.lane0[%0d]", i), 64'(a_out[7:0]), 64'(i*16));
        check($sformatf("bp.valid0[%0d]", i), 64'(a_valid[0]), 64'd1);
      end
      if (i >= 4 && i <= 8) begin
        check($sformatf("bp.lane3[%0d]", i), 64'(a_out[31:24]), 64'((i-3)*16+3));
        check($sformatf("bp.valid3[%0d]", i), 64'(a_valid[3]), 64'd1);
      end
      if (i == 8) check("bp.done", 64'(done), 64'd1);
      if (i == 9) check("bp.idle", 64'(busy), 64'd0);
    end
    check("bp.done_count", 64'(done_cnt), 64'd1);

    // Bubbles: A, two empty STREAM cycles, then B with last
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 1)      drive(1'b0, 1'b1, 32'hA3A2A1A0, 1'b0);
      else if (i == 4) drive(1'b0, 1'b1, 32'hB3B2B1B0, 1'b1);
      else             drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      for (int r = 0; r < 4; r++) begin
        logic [7:0] e_d;
        logic       e_vl;
        e_d  = 8'h00;
        e_vl = 1'b0;
        if (i == 2 + r) begin e_d = 8'hA0 + 8'(r); e_vl = 1'b1; end
        if (i == 5 + r) begin e_d = 8'hB0 + 8'(r); e_vl = 1'b1; end
        check($sformatf("bub.lane%0d[%0d]", r, i), 64'(a_out[r*8 +: 8]), 64'(e_d));
        check($sformatf("bub.valid%0d[%0d]", r, i), 64'(a_valid[r]), 64'(e_vl));
      end
      if (i == 8) check("bub.done", 64'(done), 64'd1);
      if (i == 9) check("bub.idle", 64'(state), 64'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Start pulsed during STREAM is ignored
    drive(1'b0, 1'b1, vk(1), 1'b0);
    tick();
    drive(1'b0, 1'b1, vk(2), 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      start = (i == 1);
      tick();
      done_cnt += int'(done);
      if (i == 1) check("ign.state_stream", 64'(state), 64'd1);
      if (i == 1) check("ign.lane0_v1", 64'(a_out[7:0]), 64'h10);
      if (i == 2) check("ign.state_drain", 64'(state), 64'd2);
      if (i == 2) check("ign.lane0_v2", 64'(a_out[7:0]), 64'h20);
      if (i == 5) check("ign.done", 64'(done), 64'd1);
      if (i == 6) check("ign.state_idle", 64'(state), 64'd0);
      if (i == 8) check("ign.no_restart", 64'(busy), 64'd0);
    end
    start = 1'b0;
    check("ign.done_count", 64'(done_cnt), 64'd1);

    // Reset during DRAIN with a further vector queued
    drive(1'b0, 1'b1, 32'hC3C2C1C0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'hD3D2D1D0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("rst.pre_state", 64'(state), 64'd2);
    check("rst.pre_a_out", 64'(a_out), 64'h0000C100);
    reset_n = 1'b0;
    #2;
    check_outs("rst.mid", 32'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("rst.mid.state", 64'(state), 64'd0);
    #1 reset_n = 1'b1;
    tick();
    drive(1'b0, 1'b1, 32'hE3E2E1E0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      logic [31:0] e_a;
      logic [3:0]  e_v;
      e_a = 32'h0;
      e_v = 4'h0;
      if (i <= 4) begin
        e_a = 32'hE3E2E1E0 & (32'hFF << (8*(i-1)));
        e_v = 4'(1 << (i-1));
      end
      tick();
      check($sformatf("rst.post_a_out[%0d]", i), 64'(a_out), 64'(e_a));
      check($sformatf("rst.post_a_valid[%0d]", i), 64'(a_valid), 64'(e_v));
      if (i == 4) check("rst.post_done", 64'(done), 64'd1);
    end
    check("rst.post_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
